// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multiply/divide controller.
// Holds the architectural HI/LO registers, runs a fixed-latency busy
// period for mult/div, serves mfhi/mflo combinationally, and asks the
// hazard unit to hold MDU instructions in decode while the unit is busy.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MD_Use,
  output logic [31:0] E_MulDiv_Out,
  output logic        MD_Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_ok;

  logic             start;
  logic             is_mult;
  logic             last_cycle;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_ok;

  assign start      = (state == IDLE) &&
                      ((E_MD_Op == OP_MULT) || (E_MD_Op == OP_MULTU) ||
                       (E_MD_Op == OP_DIV)  || (E_MD_Op == OP_DIVU));
  assign is_mult    = (E_MD_Op == OP_MULT) || (E_MD_Op == OP_MULTU);
  assign last_cycle = (counter == CNT_W'(1));

  assign MD_Busy  = (state == BUSY);
  assign MD_Stall = D_MD_Use & (start | MD_Busy);

  // Full 64-bit products; operands are extended to 64 bits before multiplying
  assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Arithmetic result for the op in E; a zero divisor marks the result as not to be written back
  always_comb begin
    calc_hi = '0;
    calc_lo = '0;
    calc_ok = 1'b1;
    case (E_MD_Op)
      OP_MULT:  {calc_hi, calc_lo} = prod_s;
      OP_MULTU: {calc_hi, calc_lo} = prod_u;
      OP_DIV: begin
        if (E_B == 32'd0) begin
          calc_ok = 1'b0;
        end else begin
          calc_lo = 32'($signed(E_A) / $signed(E_B));
          calc_hi = 32'($signed(E_A) % $signed(E_B));
        end
      end
      OP_DIVU: begin
        if (E_B == 32'd0) begin
          calc_ok = 1'b0;
        end else begin
          calc_lo = E_A / E_B;
          calc_hi = E_A % E_B;
        end
      end
      default: calc_ok = 1'b1;
    endcase
  end

  // mfhi/mflo read the architectural registers directly; anything else drives zero
  always_comb begin
    E_MulDiv_Out = '0;
    if (E_MD_Op == OP_MFHI) begin
      E_MulDiv_Out = HI;
    end else if (E_MD_Op == OP_MFLO) begin
      E_MulDiv_Out = LO;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter BUSY on start, leave when the countdown reaches its last cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = BUSY;
      BUSY: if (last_cycle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch results on start, count down while busy, write HI/LO at the end or on mthi/mtlo
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      res_ok  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        res_hi  <= calc_hi;
        res_lo  <= calc_lo;
        res_ok  <= calc_ok;
        counter <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (E_MD_Op == OP_MTHI) begin
        HI <= E_A;
      end else if (E_MD_Op == OP_MTLO) begin
        LO <= E_A;
      end
    end else begin
      counter <= counter - CNT_W'(1);
      if (last_cycle && res_ok) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed checks of the multiply/divide controller.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_md_unit_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  E_MD_Op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_MD_Use;
  logic [31:0] E_MulDiv_Out;
  logic        MD_Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .E_MD_Op      (E_MD_Op),
    .E_A          (E_A),
    .E_B          (E_B),
    .D_MD_Use     (D_MD_Use),
    .E_MulDiv_Out (E_MulDiv_Out),
    .MD_Busy      (MD_Busy),
    .MD_Stall     (MD_Stall),
    .HI           (HI),
    .LO           (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op in E for the cycle starting at the next falling edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    E_MD_Op = op;
    E_A     = a;
    E_B     = b;
    #1;
  endtask

  // Step cycles with no op in E, counting how many of them show MD_Busy
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      E_MD_Op = 4'd0;
      #1;
      if (!MD_Busy) break;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; E_MD_Op = 4'd0; E_A = '0; E_B = '0; D_MD_Use = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    E_MD_Op = 4'd8;
    #1;
    checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got=%h exp=%h", HI, 32'h0); end
    checks++; if (LO !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got=%h exp=%h", LO, 32'h0); end
    checks++; if (MD_Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", MD_Busy); end
    checks++; if (MD_Stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", MD_Stall); end
    checks++; if (E_MulDiv_Out !== 32'h0) begin errors++; $display("[TB] FAIL reset_mflo got=%h exp=%h", E_MulDiv_Out, 32'h0); end
  endtask

  task automatic test_mult;
    int n;
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL mult_busy_cycles got=%0d exp=5", n); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi got=%h exp=%h", HI, 32'hFFFFFFFF); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo got=%h exp=%h", LO, 32'hFFFFFFFA); end
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=5", n); end
    checks++; if (HI !== 32'h00000002) begin errors++; $display("[TB] FAIL multu_hi got=%h exp=%h", HI, 32'h2); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL multu_lo got=%h exp=%h", LO, 32'hFFFFFFFA); end
    issue(4'd7, 32'h0, 32'h0);
    checks++; if (E_MulDiv_Out !== 32'h00000002) begin errors++; $display("[TB] FAIL multu_mfhi got=%h exp=%h", E_MulDiv_Out, 32'h2); end
  endtask

  task automatic test_div;
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL div_busy_cycles got=%0d exp=10", n); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo got=%h exp=%h", LO, 32'hFFFFFFFD); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi got=%h exp=%h", HI, 32'hFFFFFFFF); end
    issue(4'd4, 32'd7, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL divu0_busy_cycles got=%0d exp=10", n); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL divu0_lo got=%h exp=%h", LO, 32'hFFFFFFFD); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu0_hi got=%h exp=%h", HI, 32'hFFFFFFFF); end
    issue(4'd4, 32'd100, 32'd7);
    count_busy(n);
    checks++; if (LO !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo got=%h exp=%h", LO, 32'd14); end
    checks++; if (HI !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi got=%h exp=%h", HI, 32'd2); end
  endtask

  task automatic test_stall;
    int sc;
    D_MD_Use = 1'b1;
    issue(4'd1, 32'h00010001, 32'h00000100);
    sc = MD_Stall ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      E_MD_Op = 4'd0;
      #1;
      if (!MD_Stall) break;
      sc++;
    end
    checks++; if (sc != 6) begin errors++; $display("[TB] FAIL stall_cycles got=%0d exp=6", sc); end
    checks++; if (MD_Stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got=%b exp=0", MD_Stall); end
    E_MD_Op = 4'd8;
    #1;
    checks++; if (E_MulDiv_Out !== 32'h01000100) begin errors++; $display("[TB] FAIL stall_mflo got=%h exp=%h", E_MulDiv_Out, 32'h01000100); end
    D_MD_Use = 1'b0;
    issue(4'd1, 32'd9, 32'd9);
    sc = MD_Stall ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      E_MD_Op = 4'd0;
      #1;
      if (MD_Stall) sc++;
    end
    checks++; if (sc != 0) begin errors++; $display("[TB] FAIL nostall_cycles got=%0d exp=0", sc); end
    checks++; if (LO !== 32'd81) begin errors++; $display("[TB] FAIL nostall_lo got=%h exp=%h", LO, 32'd81); end
  endtask

  task automatic test_mthi_mtlo;
    int n;
    issue(4'd5, 32'h12345678, 32'h0);
    issue(4'd7, 32'h0, 32'h0);
    checks++; if (E_MulDiv_Out !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_mfhi got=%h exp=%h", E_MulDiv_Out, 32'h12345678); end
    E_MD_Op = 4'd8;
    #1;
    checks++; if (E_MulDiv_Out !== 32'd81) begin errors++; $display("[TB] FAIL mthi_mflo got=%h exp=%h", E_MulDiv_Out, 32'd81); end
    issue(4'd1, 32'd5, 32'd7);
    issue(4'd6, 32'hDEADBEEF, 32'h0);
    checks++; if (MD_Busy !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_busy got=%b exp=1", MD_Busy); end
    count_busy(n);
    checks++; if (LO !== 32'd35) begin errors++; $display("[TB] FAIL mtlo_ignored_lo got=%h exp=%h", LO, 32'd35); end
    checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL mtlo_ignored_hi got=%h exp=%h", HI, 32'd0); end
  endtask

  task automatic test_reset_mid;
    int bad;
    issue(4'd5, 32'hAAAA5555, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      E_MD_Op = 4'd0;
    end
    #1;
    checks++; if (MD_Busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_busy got=%b exp=1", MD_Busy); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (MD_Busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", MD_Busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hi got=%h exp=%h", HI, 32'h0); end
    checks++; if (LO !== 32'h0) begin errors++; $display("[TB] FAIL midrst_lo got=%h exp=%h", LO, 32'h0); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (HI !== 32'h0 || LO !== 32'h0 || MD_Busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL midrst_no_writeback got=%0d bad cycles exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mthi_mtlo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide controller with HI/LO state, sitting in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and sequences a fixed-latency busy period for mult/div.
- Drives E_MulDiv_Out, which is latched by the E->M pipeline register.
- Raises a stall request so decode holds any MDU instruction until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- E_MD_Op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- E_A  input  32  forwarded rs value.
- E_B  input  32  forwarded rt value.
- D_MD_Use  input  1  D-stage instruction is any MDU op (1-8).
- E_MulDiv_Out  output  32  HI for mfhi, LO for mflo, else 0; combinational.
- MD_Busy  output  1  unit is sequencing a mult/div.
- MD_Stall  output  1  stall request to hazard unit.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset: state IDLE, counter 0, HI=0, LO=0, internal result latches 0, MD_Busy=0; E_MulDiv_Out and MD_Stall then follow their equations.
  - Reset mid-operation aborts it; HI/LO are not updated.
- States: IDLE, BUSY.
  - MD_Busy = (state == BUSY).
- start = (state == IDLE) & E_MD_Op in {1,2,3,4}.
- IDLE, on start at edge t:
  - compute result from E_A/E_B and latch into RES_HI/RES_LO.
  - counter <= MULT_CYCLES for ops 1-2, DIV_CYCLES for ops 3-4.
  - state <= BUSY.
- Arithmetic:
  - mult: signed 32x32 -> 64; {RES_HI,RES_LO} = product.
  - multu: the same, unsigned.
  - div: RES_LO = signed quotient truncated toward zero; RES_HI = remainder carrying the dividend's sign.
  - divu: the same, unsigned.
  - Division by zero: at completion HI/LO keep their old values; the unit is still busy for DIV_CYCLES.
- BUSY, each edge: counter decrements.
  - When counter == 1 at an edge: HI <= RES_HI, LO <= RES_LO, state <= IDLE.
  - Net effect: MD_Busy is high for exactly N cycles after the start cycle; the new HI/LO are visible in the cycle after the last busy cycle.
- mthi / mtlo in IDLE: HI <= E_A (or LO <= E_A) at the edge. These ops cannot cause start.
- Ops 1-6 arriving while BUSY are ignored: no state, HI/LO or counter change. The hazard unit makes this unreachable; the guard is still required.
- mfhi/mflo: E_MulDiv_Out = HI/LO combinationally.
  - While BUSY, the output returns the old HI/LO; unreachable because of the stall.
- MD_Stall = D_MD_Use & (start | MD_Busy).
  - The hazard unit freezes PC and the D register and bubbles the E register while the stall is high.
  - The stall deasserts in the cycle HI/LO update is visible, so a following mfhi reads the new value.
- No other pipeline register write-enables are driven by this block.
- Counter width: enough bits for max(MULT_CYCLES, DIV_CYCLES).

Test Plan:
- Reset: hold rst 2 cycles, then check HI=0, LO=0, MD_Busy=0, MD_Stall=0; mflo gives E_MulDiv_Out=0.
- mult E_A=0xFFFFFFFE (-2), E_B=3 -> MD_Busy high exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div E_A=-7 (0xFFFFFFF9), E_B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu E_A=7, E_B=0 -> busy 10 cycles, HI/LO unchanged.
- Stall: mult issued with D_MD_Use=1 (mflo in D) -> MD_Stall high in the start cycle plus 5 busy cycles (6 total), low on the next. mflo then yields the product low word. With D_MD_Use=0 in the same window, MD_Stall stays 0.
- mthi E_A=0x12345678, then mflo/mfhi -> HI=0x12345678. An mtlo forced while BUSY is ignored: LO ends as the mult result.
- Assert rst at busy cycle 3 of a div -> next cycle IDLE, HI=LO=0, MD_Busy=0. No late writeback occurs in the following 10 cycles.
